// File: rtl/ex_muldiv_pkg.sv
// Shared types and constants for the execute-stage multiply/divide unit.
// The op encoding matches the RV32M funct3 field so it can be driven straight from decode.
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } muldiv_state_e;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;
  localparam logic [XLEN-1:0] DIV_OVF_Q  = 32'h8000_0000;

endpackage

// File: rtl/ex_muldiv_if.sv
// Start/busy/done handshake and operand/result bus between the EX stage and the muldiv unit.
// The master side is the pipeline; the slave side is the iterative unit.
interface ex_muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = XLEN
);
  logic             start;
  logic             flush;
  logic [2:0]       MulDivOp;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] MulDivResult;
  logic             Stall;

  modport master (
    output start, flush, MulDivOp, SrcA, SrcB,
    input  Busy, Done, MulDivResult, Stall
  );

  modport slave (
    input  start, flush, MulDivOp, SrcA, SrcB,
    output Busy, Done, MulDivResult, Stall
  );
endinterface

// File: rtl/ex_muldiv.sv
// Radix-2 iterative RV32M multiply/divide: shift-add multiply, restoring divide on magnitudes,
// signs reapplied in a single FIXUP cycle. One shared 2*WIDTH accumulator serves both datapaths.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input logic        clk,
  input logic        rst,
  ex_muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_e      state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  muldiv_op_e         op_reg, op_next;
  logic               neg_q_reg, neg_q_next;
  logic               neg_r_reg, neg_r_next;
  logic [WIDTH-1:0]   a_mag_reg, a_mag_next;
  logic [WIDTH-1:0]   b_mag_reg, b_mag_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   result_reg, result_next;

  function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? ((~x) + WIDTH'(1)) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] x, input logic neg);
    return neg ? ((~x) + (2*WIDTH)'(1)) : x;
  endfunction

  muldiv_op_e       op_in;
  logic             sgn_a, sgn_b, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf;

  always_comb begin
    op_in    = muldiv_op_e'(bus.MulDivOp);
    sgn_a    = (op_in == MULH) || (op_in == MULHSU) || (op_in == DIV) || (op_in == REM);
    sgn_b    = (op_in == MULH) || (op_in == DIV) || (op_in == REM);
    a_neg    = sgn_a & bus.SrcA[WIDTH-1];
    b_neg    = sgn_b & bus.SrcB[WIDTH-1];
    a_mag    = cneg_w(bus.SrcA, a_neg);
    b_mag    = cneg_w(bus.SrcB, b_neg);
    div_zero = op_in[2] && (bus.SrcB == '0);
    div_ovf  = ((op_in == DIV) || (op_in == REM)) &&
               (bus.SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.SrcB == '1);
  end

  // Multiply step: low half holds the remaining multiplier bits, high half the partial sum.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc;
  // Divide step: high half is the partial remainder, low half shifts dividend out and quotient in.
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_acc;

  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, (acc_reg[0] ? a_mag_reg : '0)};
    mul_acc   = {mul_sum, acc_reg[WIDTH-1:1]};
    div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_mag_reg};
    div_ge    = ~div_diff[WIDTH];
    div_acc   = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc_reg[WIDTH-2:0], div_ge};
  end

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, fix_result;

  always_comb begin
    prod_s = cneg_2w(acc_reg, neg_q_reg);
    quo_s  = cneg_w(acc_reg[WIDTH-1:0], neg_q_reg);
    rem_s  = cneg_w(acc_reg[2*WIDTH-1:WIDTH], neg_r_reg);
    case (op_reg)
      MUL:             fix_result = prod_s[WIDTH-1:0];
      MULH, MULHSU,
      MULHU:           fix_result = prod_s[2*WIDTH-1:WIDTH];
      DIV, DIVU:       fix_result = quo_s;
      default:         fix_result = rem_s;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    op_next     = op_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    a_mag_next  = a_mag_reg;
    b_mag_next  = b_mag_reg;
    acc_next    = acc_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          op_next    = op_in;
          a_mag_next = a_mag;
          b_mag_next = b_mag;
          neg_q_next = a_neg ^ b_neg;
          neg_r_next = a_neg;
          cnt_next   = CW'(WIDTH-1);
          if (div_zero) begin
            result_next = ((op_in == DIV) || (op_in == DIVU)) ? DIV_ZERO_Q : bus.SrcA;
            state_next  = DONE;
          end else if (div_ovf) begin
            result_next = (op_in == DIV) ? DIV_OVF_Q : '0;
            state_next  = DONE;
          end else begin
            // Multiply shifts the multiplier through the accumulator; divide shifts the dividend.
            acc_next   = {{WIDTH{1'b0}}, (op_in[2] ? a_mag : b_mag)};
            state_next = CALC;
          end
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else begin
          acc_next = op_reg[2] ? div_acc : mul_acc;
          if (cnt_reg == '0) state_next = FIXUP;
          else               cnt_next   = cnt_reg - CW'(1);
        end
      end
      FIXUP: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else begin
          result_next = fix_result;
          state_next  = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      op_reg     <= MUL;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      a_mag_reg  <= '0;
      b_mag_reg  <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      op_reg     <= op_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      a_mag_reg  <= a_mag_next;
      b_mag_reg  <= b_mag_next;
      acc_reg    <= acc_next;
      result_reg <= result_next;
    end
  end

  always_comb begin
    bus.Busy         = (state_reg == CALC) || (state_reg == FIXUP);
    bus.Done         = (state_reg == DONE);
    bus.MulDivResult = result_reg;
    bus.Stall        = (bus.start && (state_reg == IDLE) && !bus.flush) || bus.Busy;
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized and directed check of ex_muldiv against an arithmetic RV32M reference model.
module tb_ex_muldiv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  ex_muldiv_if #(.WIDTH(32)) bus ();
  ex_muldiv #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb;
    int          ia, ib;
    logic        ovf;
    ia  = int'(a);
    ib  = int'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin sa = longint'($signed(a)); sb = longint'($signed(b)); p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin sa = longint'($signed(a)); sb = longint'({32'd0, b}); p = 64'(sa * sb); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int          exp_lat, cyc;
    logic        special, seen, stall_ok;
    exp     = ref_model(op, a, b);
    special = op[2] && ((b == 0) ||
              (((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    exp_lat = special ? 1 : 34;
    @(negedge clk);
    bus.start = 1'b1; bus.MulDivOp = op; bus.SrcA = a; bus.SrcB = b;
    #1 check("stall_start", {31'd0, bus.Stall}, 32'd1);
    @(posedge clk);
    #1 bus.start = 1'b0; bus.SrcA = $urandom; bus.SrcB = $urandom;
    cyc = 0; seen = 1'b0; stall_ok = 1'b1;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.Done) seen = 1'b1;
      else if (!bus.Stall) stall_ok = 1'b0;
      if (bus.Busy && bus.Done) stall_ok = 1'b0;
    end
    check("latency", 32'(cyc), 32'(exp_lat));
    check("result", bus.MulDivResult, exp);
    check("stall_done", {31'd0, bus.Stall}, 32'd0);
    check("stall_hold", {31'd0, stall_ok}, 32'd1);
    $display("op=%0d a=%h b=%h result=%h expected=%h latency=%0d", op, a, b, bus.MulDivResult, exp, cyc);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          dones;
    logic [31:0] prev;
    bus.start = 1'b0; bus.flush = 1'b0; bus.MulDivOp = 3'd0; bus.SrcA = '0; bus.SrcB = '0;
    #12;
    check("rst_outputs", {28'd0, bus.Busy, bus.Done, bus.Stall, 1'b0}, 32'd0);
    check("rst_result", bus.MulDivResult, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd5, 32'd100, 32'd7);
    run_op(3'd7, 32'd100, 32'd7);
    run_op(3'd5, 32'd5, 32'd0);
    run_op(3'd6, 32'd5, 32'd0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd7, 32'd100, 32'd7);

    // Flush a DIV in its tenth cycle: back to IDLE, no Done, result untouched.
    prev = bus.MulDivResult;
    @(negedge clk);
    bus.start = 1'b1; bus.MulDivOp = 3'd4; bus.SrcA = 32'd1000; bus.SrcB = 32'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'd0, bus.Busy}, 32'd0);
    dones = 0;
    repeat (40) begin @(negedge clk); if (bus.Done) dones++; end
    check("flush_nodone", 32'(dones), 32'd0);
    check("flush_result", bus.MulDivResult, prev);
    $display("flush mid-DIV: busy=%0d dones=%0d result=%h", bus.Busy, dones, bus.MulDivResult);
    run_op(3'd4, 32'd1000, 32'hFFFF_FFFD);

    // Start with flush in IDLE is not accepted.
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.MulDivOp = 3'd0; bus.SrcA = 32'd3; bus.SrcB = 32'd3;
    #1 check("flush_start_stall", {31'd0, bus.Stall}, 32'd0);
    @(posedge clk); #1 bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check("flush_start_idle", {30'd0, bus.Busy, bus.Done}, 32'd0);
    $display("start+flush in IDLE: busy=%0d done=%0d", bus.Busy, bus.Done);

    // Asynchronous reset mid-CALC clears outputs without waiting for a clock edge.
    @(negedge clk);
    bus.start = 1'b1; bus.MulDivOp = 3'd0; bus.SrcA = 32'd9; bus.SrcB = 32'd9;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_outputs", {29'd0, bus.Busy, bus.Done, bus.Stall}, 32'd0);
    check("arst_result", bus.MulDivResult, 32'd0);
    $display("async reset mid-CALC: busy=%0d result=%h", bus.Busy, bus.MulDivResult);
    @(negedge clk); rst = 1'b0;
    run_op(3'd0, 32'd6, 32'd7);

    // A start pulsed while busy is dropped: one Done, first op's result.
    @(negedge clk);
    bus.start = 1'b1; bus.MulDivOp = 3'd0; bus.SrcA = 32'd3; bus.SrcB = 32'd5;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.MulDivOp = 3'd5; bus.SrcA = 32'd1; bus.SrcB = 32'd1;
    @(negedge clk); bus.start = 1'b0;
    dones = 0;
    repeat (80) begin @(negedge clk); if (bus.Done) dones++; end
    check("busy_start_dones", 32'(dones), 32'd1);
    check("busy_start_result", bus.MulDivResult, 32'd15);
    $display("start while busy: dones=%0d result=%h", dones, bus.MulDivResult);

    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
